// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: exception codes, vector
// offsets, FSM encoding and the vector-address helper.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID_INST = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  localparam logic [11:0] VEC_OFS_INT = 12'h000;
  localparam logic [11:0] VEC_OFS_GEN = 12'h180;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Exception vector = 4 KiB-aligned page from ebase plus a fixed offset.
  function automatic logic [31:0] vec_addr(input logic [19:0] page,
                                           input logic [11:0] ofs);
    return {page, ofs};
  endfunction

endpackage

// File: rtl/pipe_ctrl_exc_vector_dec.sv
// Combinational redirect-target decode for a memory-stage exception code.
module exc_vector_dec
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] excepttype,
  input  logic [31:0] epc,
  input  logic [19:0] ebase_page,
  output logic [31:0] target
);

  // Interrupts use the base vector, eret returns to EPC, all else the general vector.
  always_comb begin
    target = 32'h0000_0000;
    case (excepttype)
      32'h0000_0000:
        target = 32'h0000_0000;
      EXC_INT:
        target = vec_addr(ebase_page, VEC_OFS_INT);
      EXC_ERET:
        target = epc;
      EXC_SYSCALL, EXC_INVALID_INST, EXC_OVERFLOW:
        target = vec_addr(ebase_page, VEC_OFS_GEN);
      default:
        target = vec_addr(ebase_page, VEC_OFS_GEN);
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall mask, multi-cycle flush with a
// latched redirect target, and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES        = 6,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic [31:0]       cp0_ebase_i,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_timeout_o
);

  localparam int WD_W = 16;

  state_e            state;
  logic [3:0]        flush_cnt;
  logic [31:0]       target_lat;
  logic [WD_W-1:0]   wd_cnt;

  logic              exc_hit;
  logic [31:0]       dec_target;
  logic [STAGES-1:0] stall_mask;
  logic              req_acc;
  logic              unused_bits;

  assign unused_bits = ^{cp0_ebase_i[11:0], stallreq_i[0]};
  assign exc_hit     = (excepttype_i != 32'h0000_0000);

  exc_vector_dec u_dec (
    .excepttype (excepttype_i),
    .epc        (cp0_epc_i),
    .ebase_page (cp0_ebase_i[31:12]),
    .target     (dec_target)
  );

  // Freeze every stage at or below the deepest requester; stage 0 never requests.
  always_comb begin
    req_acc    = 1'b0;
    stall_mask = '0;
    for (int i = STAGES - 1; i >= 1; i--) begin
      req_acc       = req_acc | stallreq_i[i];
      stall_mask[i] = req_acc;
    end
    stall_mask[0] = req_acc;
  end

  // Output selection; reset forces everything quiet regardless of inputs.
  always_comb begin
    stall  = '0;
    flush  = 1'b0;
    new_pc = 32'h0000_0000;
    if (!rst) begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = 32'h0000_0000;
    end else if (state == ST_FLUSH) begin
      flush  = 1'b1;
      new_pc = target_lat;
    end else if (exc_hit) begin
      flush  = 1'b1;
      new_pc = dec_target;
    end else begin
      stall  = stall_mask;
    end
  end

  // Pulse lands in the cycle whose stall brings the run length to the limit.
  always_comb begin
    if (rst && (stall != '0) && (wd_cnt == WD_W'(STALL_TIMEOUT - 1))) begin
      stall_timeout_o = 1'b1;
    end else begin
      stall_timeout_o = 1'b0;
    end
  end

  // RUN/FLUSH sequencing; the first flush cycle is the exception cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      flush_cnt  <= 4'd0;
      target_lat <= 32'h0000_0000;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_hit && (FLUSH_CYCLES > 1)) begin
            state      <= ST_FLUSH;
            target_lat <= dec_target;
            flush_cnt  <= 4'(FLUSH_CYCLES - 1);
          end else begin
            state      <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) begin
            state      <= ST_RUN;
            target_lat <= 32'h0000_0000;
          end else begin
            state      <= ST_FLUSH;
          end
        end
        default: begin
          state      <= ST_RUN;
          flush_cnt  <= 4'd0;
          target_lat <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Watchdog run-length counter, saturating at the limit so it pulses once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (stall == '0) begin
      wd_cnt <= '0;
    end else if (wd_cnt < WD_W'(STALL_TIMEOUT)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= wd_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (A: 3-cycle flush, 4-cycle
// watchdog; B: 4-cycle flush, default watchdog) driven by shared inputs.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [5:0]  stallreq = 6'b000000;
  logic [31:0] excepttype = 32'h0;
  logic [31:0] epc = 32'h0040_0010;
  logic [31:0] ebase = 32'h8000_1000;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [31:0] pc_a, pc_b;
  logic        to_a, to_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          sel;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        to;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(6), .FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst_a), .stallreq_i(stallreq), .excepttype_i(excepttype),
    .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall(stall_a), .flush(flush_a),
    .new_pc(pc_a), .stall_timeout_o(to_a)
  );

  pipe_ctrl #(.STAGES(6), .FLUSH_CYCLES(4), .STALL_TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst_b), .stallreq_i(stallreq), .excepttype_i(excepttype),
    .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall(stall_b), .flush(flush_b),
    .new_pc(pc_b), .stall_timeout_o(to_b)
  );

  task automatic step(input string nm, input bit chk, input bit sel,
                      input logic ra, input logic rb,
                      input logic [5:0] sr, input logic [31:0] ex,
                      input logic [5:0] e_st, input logic e_fl,
                      input logic [31:0] e_pc, input logic e_to);
    exp_t e;
    @(posedge clk);
    #1;
    rst_a = ra;
    rst_b = rb;
    stallreq = sr;
    excepttype = ex;
    if (chk) begin
      e.name = nm; e.sel = sel; e.st = e_st; e.fl = e_fl; e.pc = e_pc; e.to = e_to;
      sb.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and compares the selected instance.
  initial begin
    exp_t e;
    logic [5:0]  a_st;
    logic        a_fl;
    logic [31:0] a_pc;
    logic        a_to;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a_st = e.sel ? stall_b : stall_a;
        a_fl = e.sel ? flush_b : flush_a;
        a_pc = e.sel ? pc_b : pc_a;
        a_to = e.sel ? to_b : to_a;
        checks++;
        if (a_st !== e.st || a_fl !== e.fl || a_pc !== e.pc || a_to !== e.to) begin
          errors++;
          $display("FAIL %s: got stall=%b flush=%b new_pc=%h timeout=%b, expected stall=%b flush=%b new_pc=%h timeout=%b",
                   e.name, a_st, a_fl, a_pc, a_to, e.st, e.fl, e.pc, e.to);
        end
      end
    end
  end

  initial begin
    int waitc;
    // Reset with active inputs: outputs must be quiet.
    step("rst_a", 1, 0, 0, 0, 6'b001000, 32'h8, 6'b000000, 0, 32'h0, 0);
    step("rst_b", 1, 1, 0, 0, 6'b001000, 32'h8, 6'b000000, 0, 32'h0, 0);
    step("idle_a", 1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    // Stall mask on B
    step("mask_k3",   1, 1, 1, 1, 6'b001000, 32'h0, 6'b001111, 0, 32'h0, 0);
    step("mask_k2",   1, 1, 1, 1, 6'b000100, 32'h0, 6'b000111, 0, 32'h0, 0);
    step("mask_k32",  1, 1, 1, 1, 6'b001100, 32'h0, 6'b001111, 0, 32'h0, 0);
    step("mask_bit0", 1, 1, 1, 1, 6'b000001, 32'h0, 6'b000000, 0, 32'h0, 0);
    step("mask_k5",   1, 1, 1, 1, 6'b100000, 32'h0, 6'b111111, 0, 32'h0, 0);
    step("gap", 0, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    // Syscall with simultaneous stall on A (3-cycle flush)
    step("sys_same", 1, 0, 1, 1, 6'b001000, 32'h8, 6'b000000, 1, 32'h8000_1180, 0);
    step("sys_fl2",  1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 1, 32'h8000_1180, 0);
    step("sys_fl3",  1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 1, 32'h8000_1180, 0);
    step("sys_done", 1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    step("gap", 0, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    // Eret then a second exception that must be ignored during flush
    step("eret",      1, 0, 1, 1, 6'b000000, 32'he, 6'b000000, 1, 32'h0040_0010, 0);
    step("eret_ign1", 1, 0, 1, 1, 6'b001000, 32'h1, 6'b000000, 1, 32'h0040_0010, 0);
    step("eret_ign2", 1, 0, 1, 1, 6'b000000, 32'h1, 6'b000000, 1, 32'h0040_0010, 0);
    step("eret_done", 1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    step("gap", 0, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    // Interrupt vector
    step("int_vec", 1, 0, 1, 1, 6'b000000, 32'h1, 6'b000000, 1, 32'h8000_1000, 0);
    step("int_fl2", 1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 1, 32'h8000_1000, 0);
    for (int i = 0; i < 3; i++)
      step("gap", 0, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    // Watchdog on A: pulse in 4th stall cycle only
    for (int i = 1; i <= 10; i++)
      step($sformatf("wd_%0d", i), 1, 0, 1, 1, 6'b001000, 32'h0, 6'b001111, 0, 32'h0, (i == 4));
    step("wd_drop", 1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("wd2_%0d", i), 1, 0, 1, 1, 6'b001000, 32'h0, 6'b001111, 0, 32'h0, (i == 4));
    step("wd2_drop", 1, 0, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    // Reset in B's 2nd flush cycle
    step("rmf_exc",  1, 1, 1, 1, 6'b000000, 32'h8, 6'b000000, 1, 32'h8000_1180, 0);
    step("rmf_rst",  1, 1, 1, 0, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    step("rmf_hold", 1, 1, 1, 0, 6'b001000, 32'h8, 6'b000000, 0, 32'h0, 0);
    step("rmf_rel",  1, 1, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);
    step("rmf_run",  1, 1, 1, 1, 6'b000100, 32'h0, 6'b000111, 0, 32'h0, 0);
    // Overflow code on B: general vector, 4-cycle flush
    step("ov_vec",  1, 1, 1, 1, 6'b000000, 32'hc, 6'b000000, 1, 32'h8000_1180, 0);
    step("ov_fl2",  1, 1, 1, 1, 6'b001000, 32'h0, 6'b000000, 1, 32'h8000_1180, 0);
    step("ov_fl3",  1, 1, 1, 1, 6'b000000, 32'h0, 6'b000000, 1, 32'h8000_1180, 0);
    step("ov_fl4",  1, 1, 1, 1, 6'b000000, 32'h0, 6'b000000, 1, 32'h8000_1180, 0);
    step("ov_done", 1, 1, 1, 1, 6'b000000, 32'h0, 6'b000000, 0, 32'h0, 0);

    waitc = 0;
    while (sb.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
